// File: rtl/cpu_mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
//   mdu_op_t    : RV M-extension funct3 encoding of the eight MUL/DIV ops
//   mdu_state_t : sequencer states of cpu_mdu_seq
//   is_div / is_signed / is_rem / mul_a_signed / mul_b_signed : op decode helpers
package cpu_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    DIV_PREP = 3'd2,
    DIV_ITER = 3'd3,
    DIV_FIX  = 3'd4,
    DONE     = 3'd5
  } mdu_state_t;

  function automatic logic is_div(mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Signed division/remainder (DIV, REM).
  function automatic logic is_signed(mdu_op_t op);
    return op inside {OP_DIV, OP_REM};
  endfunction

  function automatic logic is_rem(mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as signed for MULH and MULHSU (MUL low half is sign-agnostic).
  function automatic logic mul_a_signed(mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU};
  endfunction

  function automatic logic mul_b_signed(mdu_op_t op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/cpu_mdu_divider.sv
// Unsigned radix-2 restoring divider core.
//   start     : pulse; dividend/divisor sampled and the first quotient bit produced at that edge
//   abort     : drop the current division
//   done      : high during the cycle whose closing edge produces the last quotient bit;
//               quotient/remainder are final from the following cycle
//   quotient, remainder : registered results
// A division takes XLEN edges, one quotient bit per edge (the start edge included).
module cpu_mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, quo_q, den_q;
  logic [XLEN-1:0] rem_cur, quo_cur, den_cur, rem_next, quo_next;
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [CW-1:0]   cnt;
  logic            running;

  // On start the step works on the fresh operands, so the start edge is iteration 1.
  always_comb begin
    rem_cur  = start ? '0 : rem_q;
    quo_cur  = start ? dividend : quo_q;
    den_cur  = start ? divisor : den_q;
    shifted  = {rem_cur, quo_cur[XLEN-1]};
    diff     = shifted - {1'b0, den_cur};
    // The partial remainder stays below the divisor, so bit XLEN of diff is a clean borrow.
    ge       = ~diff[XLEN];
    rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo_cur[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      den_q   <= '0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start || running) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      den_q <= den_cur;
      if (start) begin
        running <= 1'b1;
        cnt     <= CW'(XLEN - 1);
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) running <= 1'b0;
      end
    end
  end

  assign done      = running && (cnt == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/cpu_mdu_seq.sv
// Iterative multiply/divide unit for the RV M extension, sitting beside the ALU.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : op handshake; in_op (funct3), in_a (rs1), in_b (rs2), in_tag
//   flush               : squash the in-flight op and its result
//   out_valid/out_ready : result handshake; out_result, out_tag
//   busy                : op in flight or result pending (state != IDLE)
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_ready is high only in IDLE; out_valid is high only in DONE and holds, with
// out_result/out_tag frozen, until out_ready. Flush beats both handshakes.
// Latency, counted in cycles from the accept cycle to the first out_valid cycle:
// multiply MUL_LAT, divide/remainder XLEN+2, divide-by-zero/overflow early-out 1.
module cpu_mdu_seq #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  import cpu_mdu_pkg::*;

  // Pipeline depth before the result register; the result register is the last stage.
  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      state, state_d;
  mdu_op_t         in_op_e, op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            accept, early;
  logic [XLEN-1:0] early_res;
  logic            res_load;
  logic [XLEN-1:0] res_d;

  logic [2*XLEN-1:0] mul_ea, mul_eb, prod_now;
  logic [2*XLEN-1:0] mul_pipe [PD];
  logic [PD-1:0]     mul_v;

  logic            div_start, div_done;
  logic [XLEN-1:0] abs_a, abs_b, div_q, div_r, fix_q, fix_r;

  function automatic logic [XLEN-1:0] mul_pick(logic [2*XLEN-1:0] p, mdu_op_t op);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign in_op_e   = mdu_op_t'(in_op);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Divide-by-zero and signed MIN/-1 resolve at accept without iterating.
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (is_div(in_op_e)) begin
      if (in_b == '0) begin
        early     = 1'b1;
        early_res = is_rem(in_op_e) ? in_a : '1;
      end else if (is_signed(in_op_e) && in_a == XMIN && in_b == '1) begin
        early     = 1'b1;
        early_res = is_rem(in_op_e) ? '0 : XMIN;
      end
    end
  end

  // Operands sign/zero-extended to 2*XLEN; the modular product's halves are exact.
  always_comb begin
    mul_ea   = {{XLEN{mul_a_signed(in_op_e) & in_a[XLEN-1]}}, in_a};
    mul_eb   = {{XLEN{mul_b_signed(in_op_e) & in_b[XLEN-1]}}, in_b};
    prod_now = mul_ea * mul_eb;
  end

  always_ff @(posedge clk) begin
    mul_pipe[0] <= prod_now;
    for (int i = 1; i < PD; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_v <= '0;
    end else if (flush) begin
      mul_v <= '0;
    end else begin
      mul_v[0] <= accept && !is_div(in_op_e) && (MUL_LAT > 1);
      for (int i = 1; i < PD; i++) mul_v[i] <= mul_v[i-1];
    end
  end

  // Divider works on magnitudes; signs come back in DIV_FIX from the held operands.
  always_comb begin
    abs_a = (is_signed(op_q) && a_q[XLEN-1]) ? (~a_q + XLEN'(1)) : a_q;
    abs_b = (is_signed(op_q) && b_q[XLEN-1]) ? (~b_q + XLEN'(1)) : b_q;
    fix_q = (is_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? (~div_q + XLEN'(1)) : div_q;
    fix_r = (is_signed(op_q) && a_q[XLEN-1]) ? (~div_r + XLEN'(1)) : div_r;
  end

  cpu_mdu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (flush),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_d   = state;
    res_load  = 1'b0;
    res_d     = '0;
    div_start = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_div(in_op_e)) begin
              if (MUL_LAT == 1) begin
                state_d  = DONE;
                res_load = 1'b1;
                res_d    = mul_pick(prod_now, in_op_e);
              end else begin
                state_d = MUL;
              end
            end else if (early) begin
              state_d  = DONE;
              res_load = 1'b1;
              res_d    = early_res;
            end else begin
              state_d = DIV_PREP;
            end
          end
        end
        MUL: begin
          if (mul_v[PD-1]) begin
            state_d  = DONE;
            res_load = 1'b1;
            res_d    = mul_pick(mul_pipe[PD-1], op_q);
          end
        end
        DIV_PREP: begin
          div_start = 1'b1;
          state_d   = DIV_ITER;
        end
        DIV_ITER: begin
          if (div_done) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          state_d  = DONE;
          res_load = 1'b1;
          res_d    = is_rem(op_q) ? fix_r : fix_q;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q    <= in_op_e;
        a_q     <= in_a;
        b_q     <= in_b;
        out_tag <= in_tag;
      end
      if (res_load) out_result <= res_d;
    end
  end

endmodule

// File: tb/tb_cpu_mdu_seq.sv
// Self-checking bench for cpu_mdu_seq (XLEN=32, MUL_LAT=3, TAG_W=5).
module tb_cpu_mdu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  cpu_mdu_seq #(.XLEN(32), .MUL_LAT(3), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  tag_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model of the M-extension results.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as_v, bs_v;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    as_v = a;
    bs_v = b;
    r = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(as_v / bs_v);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(as_v % bs_v);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] == 1'b0) return 3;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic sb_pop_check();
    logic [31:0] e;
    logic [4:0]  t;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check("result", out_result, e);
      check("tag", 32'(out_tag), 32'(t));
    end
  endtask

  // Drive one op, check latency, hold out_ready low for 'hold' cycles, compare on handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat, input int hold);
    int cyc;
    wait_ready();
    out_ready = (hold == 0);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      exp_q.delete();
      tag_q.delete();
      out_ready = 1'b1;
      return;
    end
    check("latency", 32'(cyc), 32'(lat));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", out_result, exp);
      check("hold_tag", 32'(out_tag), 32'(tag));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sb_pop_check();
    @(posedge clk); #1;
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 3};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 3};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 3};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 3};
    vecs[4]  = '{3'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 3};
    vecs[5]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 3};
    vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
    vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
    vecs[8]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
    vecs[9]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
    vecs[10] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[11] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34};
    vecs[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[14] = '{3'd6, 32'hFFFFFFFD, 32'd0,        32'hFFFFFFFD, 1};
    vecs[15] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
    vecs[18] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
    vecs[19] = '{3'd4, 32'h80000000, 32'h00000001, 32'h80000000, 34};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // vector table
    for (int i = 0; i < 20; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, 0);

    // backpressure: DIVU 100/7 held 5 cycles
    run_op(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34, 5);

    // flush during DIV_ITER
    wait_ready();
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'h15, 32'd12, 3, 0);

    // flush together with in_valid in IDLE: op not taken
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("idle_flush_no_valid", 32'(seen), 32'd0);

    // flush wins over out_ready in DONE
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("early_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_valid", 32'(out_valid), 32'd0);
    check("done_flush_in_ready", 32'(in_ready), 32'd1);

    // reset mid-MUL
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", out_result, 32'd0);
    check("mid_rst_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // random back-to-back ops against the model
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom();
      r_b  = $urandom();
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
        2: r_b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), model(r_op, r_a, r_b),
             model_lat(r_op, r_a, r_b), $urandom_range(0, 2));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
